// File: rtl/rename_dispatch_queue.sv
// rename_dispatch_queue: elastic bundle buffer between rename and dispatch.
// Holds up to DEPTH renamed bundles. Branch resolution is applied in place:
// a verify clears the resolved tag from every lane mask, and a mispredict
// squashes tagged lanes and trims the fully squashed (youngest) bundles.
module rename_dispatch_queue #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int PKT_W          = 128,
  parameter int CHECKPOINTS    = 4,
  parameter int DEPTH          = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [DISPATCH_WIDTH-1:0]             in_lane_vld_i,
  input  logic [DISPATCH_WIDTH*PKT_W-1:0]       in_pkt_i,
  input  logic [DISPATCH_WIDTH*CHECKPOINTS-1:0] in_mask_i,
  input  logic                                  ctrl_verified_i,
  input  logic                                  ctrl_mispredict_i,
  input  logic [CHECKPOINTS-1:0]                ctrl_tag_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [DISPATCH_WIDTH-1:0]             out_lane_vld_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0]       out_pkt_o,
  output logic [DISPATCH_WIDTH*CHECKPOINTS-1:0] out_mask_o,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = DISPATCH_WIDTH * PKT_W;
  localparam int MW = DISPATCH_WIDTH * CHECKPOINTS;

  // Bundle storage; never reset, only entries inside the count are meaningful.
  logic [BW-1:0]             pkt_mem  [DEPTH];
  logic [MW-1:0]             mask_mem [DEPTH];
  logic [DISPATCH_WIDTH-1:0] lvld_mem [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, wr_idx;
  logic [CW-1:0] count_q, count_d, surv;

  logic                      mispredict, verify, enq, enq_store, deq;
  logic [MW-1:0]             clr_keep;
  logic [DISPATCH_WIDTH-1:0] in_squash, in_lvld_f;
  logic [MW-1:0]             in_mask_f;
  logic [DISPATCH_WIDTH-1:0] ent_squash [DEPTH];
  logic [DEPTH-1:0]          ent_live, ent_occ;

  // Lanes whose branch mask carries any bit of the resolved tag.
  function automatic logic [DISPATCH_WIDTH-1:0] lanes_hit(input logic [MW-1:0] m,
                                                          input logic [CHECKPOINTS-1:0] t);
    logic [DISPATCH_WIDTH-1:0] hit;
    hit = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      hit[l] = |(m[l*CHECKPOINTS +: CHECKPOINTS] & t);
    end
    return hit;
  endfunction

  // Flush and reset override any branch resolution arriving in the same cycle.
  assign mispredict = ctrl_verified_i & ctrl_mispredict_i & ~flush_i & ~reset;
  assign verify     = ctrl_verified_i & ~ctrl_mispredict_i & ~flush_i & ~reset;
  assign clr_keep   = verify ? ~{DISPATCH_WIDTH{ctrl_tag_i}} : '1;

  assign in_squash = lanes_hit(in_mask_i, ctrl_tag_i);

  // Per-entry liveness after squash and whether the slot lies inside the queue.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      wire [PW-1:0] offset = PW'(gi) - head_q;
      assign ent_squash[gi] = lanes_hit(mask_mem[gi], ctrl_tag_i);
      assign ent_occ[gi]    = CW'(offset) < count_q;
      assign ent_live[gi]   = |(lvld_mem[gi] & ~ent_squash[gi]);
    end
  endgenerate

  // No pass-through: a full buffer refuses even when the head leaves this cycle.
  assign in_ready_o  = (count_q < CW'(DEPTH)) & ~reset & ~flush_i;
  assign out_valid_o = (count_q != '0) & ~reset & ~flush_i & ~(ctrl_verified_i & ctrl_mispredict_i);
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;
  assign in_lvld_f   = mispredict ? (in_lane_vld_i & ~in_squash) : in_lane_vld_i;
  assign in_mask_f   = in_mask_i & clr_keep;
  assign enq_store   = enq & (|in_lvld_f);

  assign out_lane_vld_o = out_valid_o ? lvld_mem[head_q] : '0;
  assign out_pkt_o      = out_valid_o ? pkt_mem[head_q] : '0;
  assign out_mask_o     = out_valid_o ? (mask_mem[head_q] & clr_keep) : '0;
  assign occupancy_o    = count_q;

  // Next pointers and count; a mispredict rebuilds the tail from the surviving prefix.
  always_comb begin
    surv = '0;
    for (int e = 0; e < DEPTH; e++) begin
      surv = surv + CW'(ent_occ[e] & ent_live[e]);
    end
    head_d = head_q + PW'(deq);
    if (mispredict) begin
      wr_idx  = head_q + PW'(surv);
      tail_d  = wr_idx + PW'(enq_store);
      count_d = surv + CW'(enq_store);
    end else begin
      wr_idx  = tail_q;
      tail_d  = tail_q + PW'(enq_store);
      count_d = count_q + CW'(enq_store) - CW'(deq);
    end
  end

  // Valid state: reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset | flush_i) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage: resolve branches in place on every entry, then write the new bundle.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (verify)     mask_mem[e] <= mask_mem[e] & clr_keep;
      if (mispredict) lvld_mem[e] <= lvld_mem[e] & ~ent_squash[e];
    end
    if (enq_store) begin
      pkt_mem[wr_idx]  <= in_pkt_i;
      mask_mem[wr_idx] <= in_mask_f;
      lvld_mem[wr_idx] <= in_lvld_f;
    end
  end

endmodule

// File: tb/tb_rename_dispatch_queue.sv
// tb_rename_dispatch_queue: directed scenarios plus random traffic, applied to a
// DEPTH=2 and a DEPTH=4 instance at once, each compared against a bundle-list model.
module tb_rename_dispatch_queue;
  localparam int BW = 512;
  localparam int MW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready, cv, cm;
  logic [3:0]    in_lv, tag;
  logic [BW-1:0] in_pkt;
  logic [MW-1:0] in_mask;

  logic          ir2, ov2, ir4, ov4;
  logic [3:0]    olv2, olv4;
  logic [BW-1:0] op2, op4;
  logic [MW-1:0] om2, om4;
  logic [1:0]    occ2;
  logic [2:0]    occ4;

  rename_dispatch_queue #(.DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir2),
    .in_lane_vld_i(in_lv), .in_pkt_i(in_pkt), .in_mask_i(in_mask),
    .ctrl_verified_i(cv), .ctrl_mispredict_i(cm), .ctrl_tag_i(tag),
    .out_valid_o(ov2), .out_ready_i(out_ready), .out_lane_vld_o(olv2),
    .out_pkt_o(op2), .out_mask_o(om2), .occupancy_o(occ2));

  rename_dispatch_queue #(.DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir4),
    .in_lane_vld_i(in_lv), .in_pkt_i(in_pkt), .in_mask_i(in_mask),
    .ctrl_verified_i(cv), .ctrl_mispredict_i(cm), .ctrl_tag_i(tag),
    .out_valid_o(ov4), .out_ready_i(out_ready), .out_lane_vld_o(olv4),
    .out_pkt_o(op4), .out_mask_o(om4), .occupancy_o(occ4));

  typedef struct packed {
    logic [3:0]    lv;
    logic [BW-1:0] pkt;
    logic [MW-1:0] mask;
  } bundle_t;

  bundle_t mq [2][4];
  int      mn [2];
  int      n_vec = 0;
  int      n_miss = 0;
  int      cyc = 0;
  int      tags_q[$];

  task automatic check_val(input string tag_s, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag_s, obs, exp);
    end
  endtask

  function automatic logic [3:0] hit_lanes(input logic [MW-1:0] m, input logic [3:0] t);
    logic [3:0] h;
    for (int l = 0; l < 4; l++) h[l] = ((m[4*l +: 4] & t) != 4'd0);
    return h;
  endfunction

  task automatic set_in(input logic r, input logic f, input logic iv, input logic [3:0] lv,
                        input logic [MW-1:0] mk, input logic orr, input logic c_v,
                        input logic c_m, input logic [3:0] t);
    reset = r; flush = f; in_valid = iv; in_lv = lv; in_mask = mk;
    out_ready = orr; cv = c_v; cm = c_m; tag = t;
    for (int i = 0; i < 16; i++) in_pkt[32*i +: 32] = $urandom;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Compare one instance with the model for the current inputs, then advance the model.
  task automatic model_cycle(input int k);
    int d, n, w;
    logic mp, vf, e_ir, e_ov;
    logic [MW-1:0] keep;
    bundle_t b;
    logic o_ir, o_ov;
    logic [3:0] o_lv;
    logic [BW-1:0] o_pkt;
    logic [MW-1:0] o_mask;
    int o_occ;
    string px;
    d  = (k == 0) ? 2 : 4;
    px = (k == 0) ? "d2" : "d4";
    n  = mn[k];
    mp = cv & cm & ~flush & ~reset;
    vf = cv & ~cm & ~flush & ~reset;
    keep = vf ? ~{4{tag}} : '1;
    e_ir = (n < d) && !reset && !flush;
    e_ov = (n != 0) && !reset && !flush && !(cv && cm);
    if (k == 0) begin
      o_ir = ir2; o_ov = ov2; o_lv = olv2; o_pkt = op2; o_mask = om2; o_occ = int'(occ2);
    end else begin
      o_ir = ir4; o_ov = ov4; o_lv = olv4; o_pkt = op4; o_mask = om4; o_occ = int'(occ4);
    end
    check_val({px, ".in_ready"}, o_ir, e_ir);
    check_val({px, ".out_valid"}, o_ov, e_ov);
    check_val({px, ".occupancy"}, o_occ, n);
    check_val({px, ".lane_vld"}, o_lv, e_ov ? mq[k][0].lv : 4'h0);
    check_val({px, ".mask"}, o_mask, e_ov ? (mq[k][0].mask & keep) : '0);
    check_val({px, ".pkt"}, o_pkt, e_ov ? mq[k][0].pkt : '0);
    if (reset || flush) begin
      n = 0;
    end else begin
      if (mp) begin
        w = 0;
        for (int i = 0; i < n; i++) begin
          b = mq[k][i];
          b.lv = b.lv & ~hit_lanes(b.mask, tag);
          if (b.lv != 4'h0) begin
            mq[k][w] = b;
            w++;
          end
        end
        n = w;
      end
      if (vf) for (int i = 0; i < n; i++) mq[k][i].mask = mq[k][i].mask & keep;
      if (e_ov && out_ready) begin
        for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
        n--;
      end
      if (in_valid && e_ir) begin
        b.lv   = mp ? (in_lv & ~hit_lanes(in_mask, tag)) : in_lv;
        b.pkt  = in_pkt;
        b.mask = in_mask & keep;
        if (b.lv != 4'h0) begin
          mq[k][n] = b;
          n++;
        end
      end
    end
    mn[k] = n;
  endtask

  task automatic tick();
    #2;
    model_cycle(0);
    model_cycle(1);
    $display("cyc %0d rst=%0b fl=%0b in_v=%0b lv=%h mask=%h out_r=%0b ctrl=%0b%0b tag=%b occ2=%0d occ4=%0d",
             cyc, reset, flush, in_valid, in_lv, in_mask, out_ready, cv, cm, tag, mn[0], mn[1]);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic [MW-1:0] mk);
    set_in(1'b0, 1'b0, 1'b1, 4'hF, mk, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
  endtask

  task automatic do_flush();
    set_in(1'b0, 1'b1, 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
  endtask

  initial begin
    int ix, st, ft;
    logic c_v, c_m;
    logic [3:0] t, cur;
    logic [MW-1:0] mk;
    logic f;
    mn[0] = 0;
    mn[1] = 0;
    set_in(1'b1, 1'b0, 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();

    // Reset state
    idle(); #2;
    check_val("rst.occ", occ2, 0);
    check_val("rst.out_valid", ov2, 0);
    tick();

    // Three offers with dispatch stalled: two taken
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 4'hF, '0, 1'b0, 1'b0, 1'b0, 4'h0); #2;
      if (i == 2) check_val("full.in_ready", ir2, 0);
      tick();
    end
    idle(); #2;
    check_val("full.occ", occ2, 2);
    tick();

    // Full with offer and dequeue: no pass-through
    set_in(1'b0, 1'b0, 1'b1, 4'hF, '0, 1'b1, 1'b0, 1'b0, 4'h0); #2;
    check_val("fullpop.in_ready", ir2, 0);
    check_val("fullpop.out_valid", ov2, 1);
    tick();
    idle(); #2;
    check_val("fullpop.occ", occ2, 1);
    tick();

    // Flush while full with an offer
    push('0);
    set_in(1'b0, 1'b1, 1'b1, 4'hF, '0, 1'b1, 1'b0, 1'b0, 4'h0); #2;
    check_val("flush.in_ready", ir2, 0);
    check_val("flush.out_valid", ov2, 0);
    tick();
    idle(); #2;
    check_val("flush.occ", occ2, 0);
    tick();

    // Verify clears the tag from the head mask in the same cycle and keeps it cleared
    push(16'h2222);
    set_in(1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b0, 4'b0010); #2;
    check_val("vfy.same_cycle", om2, 0);
    tick();
    idle(); #2;
    check_val("vfy.after_valid", ov2, 1);
    check_val("vfy.after_mask", om2, 0);
    tick();
    do_flush();

    // Mispredict squashing lanes 2,3 of the younger entry
    push('0);
    push(16'h4400);
    set_in(1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b1, 1'b1, 1'b1, 4'b0100); #2;
    check_val("mp.out_valid", ov2, 0);
    tick();
    idle(); #2;
    check_val("mp.occ", occ2, 2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b0, 4'h0); #2;
    check_val("mp.head0_lanes", olv2, 4'hF);
    tick();
    idle(); #2;
    check_val("mp.entry1_lanes", olv2, 4'b0011);
    tick();
    do_flush();

    // Mispredict squashing a whole entry, then a fully tagged offer is dropped
    push('0);
    push(16'h4444);
    set_in(1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 1'b1, 4'b0100);
    tick();
    idle(); #2;
    check_val("mpall.occ", occ2, 1);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 4'hF, 16'h4444, 1'b0, 1'b1, 1'b1, 4'b0100); #2;
    check_val("mpall.in_ready", ir2, 1);
    tick();
    idle(); #2;
    check_val("mpall.drop_occ", occ2, 1);
    tick();
    do_flush();

    // Random traffic with tags allocated in program order so squashes stay a suffix
    for (int c = 0; c < 400; c++) begin
      f   = ($urandom_range(0, 39) == 0);
      c_v = 1'b0; c_m = 1'b0; t = 4'h0; ix = 0;
      if (tags_q.size() > 0 && $urandom_range(0, 3) == 0) begin
        ix  = $urandom_range(0, tags_q.size() - 1);
        t   = 4'(1 << tags_q[ix]);
        c_v = 1'b1;
        c_m = ($urandom_range(0, 4) < 2);
      end
      cur = 4'h0;
      foreach (tags_q[i]) cur = cur | 4'(1 << tags_q[i]);
      for (int l = 0; l < 4; l++) begin
        mk[4*l +: 4] = cur;
        if (!(c_v && c_m) && cur != 4'hF && $urandom_range(0, 3) == 0) begin
          st = $urandom_range(0, 3);
          ft = -1;
          for (int j = 0; j < 4; j++) if (ft < 0 && !cur[(st + j) % 4]) ft = (st + j) % 4;
          tags_q.push_back(ft);
          cur = cur | 4'(1 << ft);
        end
      end
      set_in(1'b0, f, ($urandom_range(0, 9) < 7), 4'($urandom), mk,
             ($urandom_range(0, 9) < 6), c_v, c_m, t);
      if (f) tags_q.delete();
      else if (c_v && !c_m) tags_q.delete(ix);
      else if (c_v && c_m) while (tags_q.size() > ix) tags_q.pop_back();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
